// File: rtl/read_src_fsm_if.sv
// AXI read-channel bundle (AR + R) between the source-read stage and memory.
// master: DMA side drives AR and rready; slave: memory side drives R.
interface read_src_fsm_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/read_src_fsm.sv
// Source-read stage: one INCR read burst per descriptor, beats pushed to FIFO.
// Ports: clk/reset_n, descriptor in, AXI read master (axi), FIFO push, status/perf.
module read_src_fsm #(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 64,
  parameter int LENGTH_W    = 24,
  parameter int PERF_CNTR_W = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   descriptor_fifo_not_empty,
  input  logic                   desc_go,
  input  logic [ADDR_W-1:0]      desc_src_addr,
  input  logic [LENGTH_W-1:0]    desc_length,
  input  logic                   csr_reset_dispatcher,
  read_src_fsm_if.master         axi,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  output logic                   rd_fsm_done,
  output logic [4:0]             rd_state,
  output logic                   busy,
  output logic                   stopped_on_error,
  output logic                   rd_rsp_err,
  output logic [PERF_CNTR_W-1:0] rd_clk_cnt,
  output logic [PERF_CNTR_W-1:0] rd_valid_cnt
);

  localparam logic [2:0] SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [4:0] {
    IDLE           = 5'b00001,
    ADDR_SETUP     = 5'b00010,
    RD_SRC_WR_FIFO = 5'b00100,
    DONE           = 5'b01000,
    ERROR          = 5'b10000
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        arlen_q;
  logic [7:0]        beat_q;
  logic              arvalid_q;

  logic start;
  logic len_ok;
  logic beat;
  logic rsp_ok;
  logic last_beat;

  assign start = desc_go & descriptor_fifo_not_empty;

  // Legal burst lengths are 1..256 beats.
  assign len_ok = (desc_length != '0) &&
                  (desc_length <= LENGTH_W'(256));

  assign rsp_ok    = (axi.rresp == 2'b00);
  assign last_beat = (beat_q == arlen_q);

  always_comb begin
    state_d    = state_q;
    axi.rready = 1'b0;
    beat       = 1'b0;
    fifo_wr_en = 1'b0;
    unique case (1'b1)
      state_q[0]: begin
        if (start)
          state_d = len_ok ? ADDR_SETUP : ERROR;
      end
      state_q[1]: begin
        if (arvalid_q && axi.arready)
          state_d = RD_SRC_WR_FIFO;
      end
      state_q[2]: begin
        axi.rready = ~fifo_full;
        beat       = axi.rvalid & ~fifo_full;
        fifo_wr_en = beat & rsp_ok;
        if (beat) begin
          if (!rsp_ok)
            state_d = ERROR;
          else if (axi.rlast != last_beat)
            state_d = ERROR;
          else if (last_beat)
            state_d = DONE;
        end
      end
      state_q[3]: begin
        state_d = IDLE;
      end
      state_q[4]: begin
        // Swallow whatever the source still has in flight.
        axi.rready = 1'b1;
        if (csr_reset_dispatcher)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      arlen_q      <= '0;
      beat_q       <= '0;
      arvalid_q    <= 1'b0;
      busy         <= 1'b0;
      rd_rsp_err   <= 1'b0;
      rd_clk_cnt   <= '0;
      rd_valid_cnt <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= (state_d == ADDR_SETUP);
      unique case (1'b1)
        state_q[0]: begin
          if (start) begin
            addr_q       <= desc_src_addr;
            arlen_q      <= desc_length[7:0] - 8'd1;
            beat_q       <= '0;
            busy         <= 1'b1;
            rd_clk_cnt   <= '0;
            rd_valid_cnt <= '0;
          end
        end
        state_q[2]: begin
          rd_clk_cnt <= rd_clk_cnt + 1'b1;
          if (beat) begin
            beat_q       <= beat_q + 8'd1;
            rd_valid_cnt <= rd_valid_cnt + 1'b1;
            if (!rsp_ok)
              rd_rsp_err <= 1'b1;
          end
        end
        state_q[3]: begin
          busy <= 1'b0;
        end
        state_q[4]: begin
          if (csr_reset_dispatcher) begin
            busy       <= 1'b0;
            rd_rsp_err <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign axi.arvalid      = arvalid_q;
  assign axi.araddr       = addr_q;
  assign axi.arlen        = arlen_q;
  assign axi.arsize       = SIZE;
  assign axi.arburst      = 2'b01;
  assign fifo_wr_data     = axi.rdata;
  assign rd_fsm_done      = (state_q == DONE);
  assign stopped_on_error = (state_q == ERROR);
  assign rd_state         = state_q;

endmodule

// File: tb/tb_read_src_fsm.sv
// Bench for read_src_fsm: directed + random bursts vs a queue-based model.
// Inputs change on negedge, outputs sampled 1 time unit later.
module tb_read_src_fsm;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int LW = 24;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          not_empty = 1'b0;
  logic          desc_go = 1'b0;
  logic [AW-1:0] desc_src_addr = '0;
  logic [LW-1:0] desc_length = '0;
  logic          csr_rst = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          rd_fsm_done;
  logic [4:0]    rd_state;
  logic          busy;
  logic          stopped_on_error;
  logic          rd_rsp_err;
  logic [PW-1:0] rd_clk_cnt;
  logic [PW-1:0] rd_valid_cnt;

  read_src_fsm_if #(.DATA_W(DW), .ADDR_W(AW)) axi ();

  read_src_fsm #(
    .DATA_W(DW), .ADDR_W(AW),
    .LENGTH_W(LW), .PERF_CNTR_W(PW)
  ) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .descriptor_fifo_not_empty (not_empty),
    .desc_go                   (desc_go),
    .desc_src_addr             (desc_src_addr),
    .desc_length               (desc_length),
    .csr_reset_dispatcher      (csr_rst),
    .axi                       (axi),
    .fifo_full                 (fifo_full),
    .fifo_wr_en                (fifo_wr_en),
    .fifo_wr_data              (fifo_wr_data),
    .rd_fsm_done               (rd_fsm_done),
    .rd_state                  (rd_state),
    .busy                      (busy),
    .stopped_on_error          (stopped_on_error),
    .rd_rsp_err                (rd_rsp_err),
    .rd_clk_cnt                (rd_clk_cnt),
    .rd_valid_cnt              (rd_valid_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 1;
  localparam int S_AR   = 2;
  localparam int S_RD   = 4;
  localparam int S_DONE = 8;
  localparam int S_ERR  = 16;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [DW-1:0] got_q[$];

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic smp();
    if (fifo_wr_en === 1'b1)
      got_q.push_back(fifo_wr_data);
    if (rd_fsm_done === 1'b1)
      done_cnt++;
  endtask

  task automatic tick();
    #1;
    smp();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++)
      d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk_pushes(input string tag,
                            input logic [DW-1:0] exp_q[$]);
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size())
        chk({tag, "_data"}, got_q[k], exp_q[k]);
  endtask

  // mode: 0 no backpressure, 1 full toggles every 2 cycles,
  // 2 random full and random rvalid gaps.
  task automatic run_burst(input logic [AW-1:0] addr,
                           input int len,
                           input int err_idx,
                           input int last_idx,
                           input int mode,
                           input int rst_idx);
    logic [DW-1:0] d[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pre_q[$];
    int i;
    int cyc;
    int term;
    int w;
    bit acc;
    bit is_err;
    for (int k = 0; k < len; k++)
      d.push_back(rnd_data());
    term = (err_idx >= 0) ? err_idx :
           (last_idx >= 0) ? last_idx : len - 1;
    is_err = (err_idx >= 0) || (last_idx >= 0);
    for (int k = 0; k <= term; k++)
      if (k != err_idx)
        exp_q.push_back(d[k]);
    got_q.delete();
    done_cnt = 0;

    desc_src_addr = addr;
    desc_length   = LW'(len);
    desc_go       = 1'b1;
    not_empty     = 1'b1;
    tick();
    desc_go   = 1'b0;
    not_empty = 1'b0;
    chk("st_setup", rd_state, S_AR);
    chk("busy_set", busy, 1);
    chk("clk_cnt_clr", rd_clk_cnt, 0);

    w = $urandom_range(0, 2);
    for (int k = 0; k < w; k++) begin
      chk("arvalid_hold", axi.arvalid, 1);
      tick();
    end
    chk("arvalid", axi.arvalid, 1);
    chk("araddr", axi.araddr, addr);
    chk("arlen", axi.arlen, len - 1);
    chk("arsize", axi.arsize, 6);
    chk("arburst", axi.arburst, 1);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("arvalid_drop", axi.arvalid, 0);
    chk("st_rd", rd_state, S_RD);

    i = 0;
    cyc = 0;
    while (i <= term && cyc < 4000) begin
      if (mode == 1)
        fifo_full = ((cyc / 2) % 2) == 1;
      else if (mode == 2)
        fifo_full = ($urandom_range(0, 3) == 0);
      else
        fifo_full = 1'b0;
      axi.rvalid = (mode == 2) ?
                   ($urandom_range(0, 3) != 0) : 1'b1;
      axi.rdata  = d[i];
      axi.rresp  = (i == err_idx) ? 2'd2 : 2'd0;
      axi.rlast  = (i == len - 1) || (i == last_idx);
      if (i == rst_idx) begin
        reset_n = 1'b0;
        #1;
        chk("rst_state", rd_state, S_IDLE);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clk_cnt", rd_clk_cnt, 0);
        chk("rst_valid_cnt", rd_valid_cnt, 0);
        for (int k = 0; k < rst_idx; k++)
          pre_q.push_back(d[k]);
        chk_pushes("rst_push", pre_q);
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        fifo_full  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", rd_state, S_IDLE);
        return;
      end
      #1;
      chk("rready", axi.rready, !fifo_full);
      acc = axi.rvalid && !fifo_full;
      smp();
      @(negedge clk);
      if (acc)
        i++;
      cyc++;
    end
    chk("beats_accepted", i, term + 1);
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    fifo_full  = 1'b0;
    chk("rd_clk_cnt", rd_clk_cnt, cyc);
    chk("rd_valid_cnt", rd_valid_cnt, term + 1);
    if (mode == 1)
      chk("clk_gt_valid", rd_clk_cnt > rd_valid_cnt, 1);

    if (is_err) begin
      chk("st_err", rd_state, S_ERR);
      chk("stopped", stopped_on_error, 1);
      chk("rsp_err", rd_rsp_err, err_idx >= 0);
      for (int k = term + 1; k < len; k++) begin
        fifo_full  = 1'b1;
        axi.rvalid = 1'b1;
        axi.rdata  = d[k];
        axi.rresp  = 2'd0;
        axi.rlast  = (k == len - 1);
        #1;
        chk("drain_rready", axi.rready, 1);
        chk("drain_wr_en", fifo_wr_en, 0);
        smp();
        @(negedge clk);
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      fifo_full  = 1'b0;
      chk("err_hold_cnt", rd_valid_cnt, term + 1);
      chk("err_no_done", done_cnt, 0);
      chk_pushes("err_push", exp_q);
      csr_rst = 1'b1;
      tick();
      csr_rst = 1'b0;
      chk("clr_state", rd_state, S_IDLE);
      chk("clr_stopped", stopped_on_error, 0);
      chk("clr_rsp_err", rd_rsp_err, 0);
      chk("clr_busy", busy, 0);
    end else begin
      chk("st_done", rd_state, S_DONE);
      tick();
      tick();
      chk("done_once", done_cnt, 1);
      chk("done_idle", rd_state, S_IDLE);
      chk("done_busy", busy, 0);
      chk("hold_valid", rd_valid_cnt, len);
      chk("hold_clk", rd_clk_cnt, cyc);
      chk_pushes("push", exp_q);
    end
  endtask

  task automatic run_bad_len(input int len);
    desc_src_addr = 64'h8000;
    desc_length   = LW'(len);
    desc_go       = 1'b1;
    not_empty     = 1'b1;
    tick();
    chk("bad_state", rd_state, S_ERR);
    chk("bad_stopped", stopped_on_error, 1);
    chk("bad_rsp_err", rd_rsp_err, 0);
    desc_length = LW'(4);
    for (int k = 0; k < 3; k++) begin
      chk("bad_arvalid", axi.arvalid, 0);
      tick();
    end
    chk("go_ignored", rd_state, S_ERR);
    desc_go   = 1'b0;
    not_empty = 1'b0;
    csr_rst   = 1'b1;
    tick();
    csr_rst = 1'b0;
    chk("bad_clr_state", rd_state, S_IDLE);
    chk("bad_clr_busy", busy, 0);
    chk("bad_clr_stop", stopped_on_error, 0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rl;
    int re;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'd0;
    axi.rlast   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", rd_state, S_IDLE);
    chk("reset_arvalid", axi.arvalid, 0);
    chk("reset_rready", axi.rready, 0);
    chk("reset_wr_en", fifo_wr_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", rd_fsm_done, 0);
    chk("reset_err", rd_rsp_err, 0);
    chk("reset_clk_cnt", rd_clk_cnt, 0);
    chk("reset_valid_cnt", rd_valid_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_burst(64'h1000, 4, -1, -1, 0, -1);
    run_burst(64'h2000, 8, -1, -1, 1, -1);
    run_burst(64'h3000, 4, 2, -1, 0, -1);
    run_burst(64'h4000, 4, -1, 1, 0, -1);
    run_bad_len(0);
    run_bad_len(257);
    run_burst(64'h5000, 8, -1, -1, 0, 2);
    run_burst(64'h6000, 8, -1, -1, 0, -1);
    run_burst(64'h7000, 1, -1, -1, 2, -1);
    run_burst(64'h9000, 256, -1, -1, 2, -1);

    for (int n = 0; n < 8; n++) begin
      ra = {$urandom, $urandom} & ~64'h3F;
      rl = $urandom_range(1, 32);
      re = ($urandom_range(0, 3) == 0) ?
           $urandom_range(0, rl - 1) : -1;
      run_burst(ra, rl, re, -1, 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
